// File: rtl/ram_rtl_pkg.sv
// ram_rtl_pkg: default sizes, clear-FSM states and the read-pipeline record for ram_dp_param.
package ram_rtl_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
  typedef struct packed {
    logic valid;
    logic err;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rd_pipe_t;
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: RD_LAT-deep read-result pipeline; each stage keeps its data while idle so the output holds.
module ram_rd_pipe import ram_rtl_pkg::*; #(
  parameter int RD_LAT = 1,
  parameter type pipe_t = rd_pipe_t
) (
  input  logic  clock,
  input  logic  resetn,
  input  pipe_t d,
  output pipe_t q
);
  pipe_t s [RD_LAT];
  pipe_t src [RD_LAT];
  always_comb begin
    src[0] = d;
    for (int i = 1; i < RD_LAT; i++) src[i] = s[i-1];
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) for (int i = 0; i < RD_LAT; i++) s[i] <= '0;
    else for (int i = 0; i < RD_LAT; i++) begin
      s[i].valid <= src[i].valid;
      s[i].err <= src[i].err;
      if (src[i].valid) s[i].data <= src[i].data;
    end
  assign q = s[RD_LAT-1];
endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised simple-dual-port RAM with byte enables, pipelined reads and a clear engine.
// Define RAM_BYPASS_EN for write-through on a same-address read/write; otherwise reads are read-first.
module ram_dp_param import ram_rtl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    clr_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  // Same record as rd_pipe_t, sized to this instance's data width.
  typedef struct packed {
    logic valid;
    logic err;
    logic [DATA_WIDTH-1:0] data;
  } pipe_t;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  clr_state_e state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic start, wr_in, rd_in, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;
  pipe_t rd_d, rd_q;
  assign busy = state == CLEAR;
  assign clr_done = state == DONE;
  assign start = state == IDLE && clr_req;
  assign wr_in = {1'b0, wr_addr} < LIM;
  assign rd_in = {1'b0, rd_addr} < LIM;
  assign wr_ok = wr_en && !busy && !start && wr_in;
  assign rd_ok = rd_en && !busy && !start;
  always_comb begin
    wr_word = wr_in ? mem[wr_addr[IW-1:0]] : '0;
    for (int i = 0; i < NB; i++) if (wr_be[i]) wr_word[8*i +: 8] = wr_data[8*i +: 8];
  end
  always_comb begin
    rd_word = rd_in ? mem[rd_addr[IW-1:0]] : '0;
`ifdef RAM_BYPASS_EN
    if (wr_ok && wr_addr == rd_addr) rd_word = wr_word;
`endif
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= start ? CLEAR : busy ? (cnt == LAST ? DONE : CLEAR) : clr_done ? IDLE : state;
      cnt <= busy ? cnt + 1'b1 : '0;
    end
  always_ff @(posedge clock)
    if (busy) mem[cnt[IW-1:0]] <= '0;
    else if (wr_ok) mem[wr_addr[IW-1:0]] <= wr_word;
  assign rd_d = '{valid: rd_ok, err: rd_ok && !rd_in, data: rd_word};
  ram_rd_pipe #(.RD_LAT(RD_LAT), .pipe_t(pipe_t)) u_rd_pipe (
    .clock (clock),
    .resetn(resetn),
    .d     (rd_d),
    .q     (rd_q)
  );
  assign rd_data = rd_q.data;
  assign rd_valid = rd_q.valid;
  assign rd_err = rd_q.err;
endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: directed checks of ram_dp_param at DEPTH=16, 32-bit words, RD_LAT=2, 5-bit addresses.
module tb_ram_dp_param;
  logic clock, resetn, wr_en, rd_en, clr_req, rd_valid, rd_err, busy, clr_done;
  logic [4:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0] wr_be;
  logic [31:0] m [16];
  int total = 0, bad = 0;
  ram_dp_param #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .RD_LAT(2)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    step;
    wr_en = 0;
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] ed, input logic ee);
    rd_en = 1; rd_addr = a;
    step;
    rd_en = 0;
    step;
    chk({tag, "_v"}, 32'(rd_valid), 1);
    chk({tag, "_d"}, rd_data, ed);
    chk({tag, "_e"}, 32'(rd_err), 32'(ee));
  endtask
  initial begin
    int n;
    logic saw;
    resetn = 0; wr_en = 0; rd_en = 0; clr_req = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0; wr_be = 0;
    repeat (2) step;
    chk("rst_data", rd_data, 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_err", 32'(rd_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    resetn = 1;
    step;
    clr_req = 1;
    step;
    clr_req = 0; rd_en = 1; rd_addr = 2;
    n = 0; saw = 0;
    while (busy && n < 100) begin
      n++;
      saw |= rd_valid;
      step;
    end
    rd_en = 0;
    chk("clr_busy_cycles", n, 16);
    chk("clr_no_valid", 32'(saw), 0);
    chk("clr_done_pulse", 32'(clr_done), 1);
    step;
    chk("clr_done_single", 32'(clr_done), 0);
    chk("clr_late_valid", 32'(rd_valid), 0);
    for (int i = 0; i < 16; i++) m[i] = 0;
    for (int i = 0; i < 16; i++) rd($sformatf("clr_w%0d", i), 5'(i), 0, 0);
    wr(3, 32'hDEADBEEF, 4'hF); m[3] = 32'hDEADBEEF;
    rd_en = 1; rd_addr = 3;
    step;
    rd_en = 0;
    chk("lat_early_valid", 32'(rd_valid), 0);
    step;
    chk("lat_valid", 32'(rd_valid), 1);
    chk("lat_data", rd_data, 32'hDEADBEEF);
    chk("lat_err", 32'(rd_err), 0);
    wr(5, 32'h11223344, 4'hF);
    wr(5, 32'hAABBCCDD, 4'b0101); m[5] = 32'h11BB33DD;
    rd("be", 5, 32'h11BB33DD, 0);
    rd("oor_rd", 20, 0, 1);
    wr(20, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 16; i++) rd($sformatf("oor_w%0d", i), 5'(i), m[i], 0);
    wr_en = 1; wr_addr = 7; wr_data = 32'h55; wr_be = 4'hF;
    rd_en = 1; rd_addr = 7;
    step;
    wr_en = 0; rd_en = 0;
    step;
`ifdef RAM_BYPASS_EN
    chk("same_addr", rd_data, 32'h55);
`else
    chk("same_addr", rd_data, 32'h0);
`endif
    m[7] = 32'h55;
    rd("after_same", 7, 32'h55, 0);
    rd_en = 1; rd_addr = 3;
    step;
    rd_addr = 5;
    step;
    rd_en = 0;
    chk("b2b_0", rd_data, 32'hDEADBEEF);
    step;
    chk("b2b_1_v", 32'(rd_valid), 1);
    chk("b2b_1", rd_data, 32'h11BB33DD);
    step;
    chk("hold_v", 32'(rd_valid), 0);
    chk("hold_d", rd_data, 32'h11BB33DD);
    for (int i = 0; i < 16; i++) begin
      wr(5'(i), 32'hC0DE0000 + 32'(i), 4'hF);
      m[i] = 32'hC0DE0000 + 32'(i);
    end
    clr_req = 1; wr_en = 1; wr_addr = 10; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    step;
    clr_req = 0; wr_en = 0;
    repeat (6) step;
    resetn = 0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(rd_valid), 0);
    chk("abort_done", 32'(clr_done), 0);
    #2 resetn = 1;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      saw |= clr_done | busy;
    end
    chk("abort_no_done", 32'(saw), 0);
    for (int i = 0; i < 6; i++) m[i] = 0;
    for (int i = 0; i < 16; i++) rd($sformatf("abort_w%0d", i), 5'(i), m[i], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, both on a single clock.
- Next generation of the team's fixed 8x16 dual-port RAM. Adds configurable width and depth, byte-enable writes, a configurable read latency with a valid strobe, out-of-range address handling, and a hardware clear engine.
- Serves as the DUT for the existing RAM class-based testbench flow.

Parameters:
- DATA_WIDTH, 32, data bits per word; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address port width.
- RD_LAT, 1, read latency in cycles; legal range 1..4.

Ports:
- clock  in  1  single clock; all logic updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i enables byte i.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- rd_err  out  1  asserted with rd_valid when the read address was out of range.
- clr_req  in  1  starts a full-array clear.
- busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (resetn low, asynchronous):
  - rd_data=0, rd_valid=0, rd_err=0, busy=0, clr_done=0.
  - Read pipeline is flushed, FSM goes to IDLE, clear counter=0.
  - Array contents are not reset.
- Write: when wr_en=1, busy=0 and wr_addr<DEPTH, each byte i with wr_be[i]=1 is updated at the clock edge. Bytes with wr_be[i]=0 keep their value.
- Write, out of range: if wr_addr>=DEPTH the write is silently dropped.
- Read: rd_en=1 sampled at edge N gives rd_valid=1 and rd_data after edge N+RD_LAT-1 (RD_LAT=1 means data is visible the cycle after the request).
  - The pipeline carries the valid and err flags alongside the data.
  - Back-to-back reads are fully pipelined, one result per cycle.
- Read, out of range: if rd_addr>=DEPTH, rd_data=0 and rd_err=1, with the same latency.
- When no read result is valid, rd_valid=0 and rd_data holds its last value.
- Same-address read and write in the same cycle: read-first (returns the old word), unless the optional feature below is compiled in.
- Clear FSM:
  - IDLE: clr_req=1 goes to CLEAR, with busy=1 and counter=0.
  - CLEAR: writes zero to word[counter] each cycle, counter++. When counter==DEPTH-1, goes to DONE.
  - DONE: clr_done=1 for one cycle, busy=0, then IDLE.
  - busy is high for exactly DEPTH cycles.
- While busy=1:
  - wr_en and rd_en are ignored; no rd_valid is generated.
  - Reads already in the pipeline still complete.
  - clr_req is ignored.
- clr_req in the same cycle as wr_en/rd_en: the clear wins; the write and read are dropped.
- resetn asserted mid-clear aborts the clear: busy=0, no clr_done, array partially cleared.

Optional Feature:
- Macro: RAM_BYPASS_EN.
- Defined: a same-address read and write in the same cycle returns write-through data. Bytes with wr_be=1 take wr_data; other bytes take the old word. Latency is unchanged.
- Undefined: read-first behaviour as above, with no bypass mux.

Decomposition:
- New RTL package ram_rtl_pkg (kept separate from the testbench package) holds:
  - localparams for the default width and depth;
  - the FSM state enum clr_state_e {IDLE, CLEAR, DONE};
  - typedef rd_pipe_t: a struct of valid, err and data.
- One sub-module, ram_rd_pipe: an RD_LAT-deep register pipeline of rd_pipe_t with asynchronous active-low reset.
- Array, write logic, bypass and FSM stay in ram_dp_param.

Test Plan:
- Write addr 3 = 0xDEADBEEF, be=4'hF; read addr 3 with RD_LAT=2 -> rd_valid and rd_data=0xDEADBEEF exactly 2 cycles after rd_en, rd_err=0.
- Write addr 5 = 0x11223344 (be=F), then write 0xAABBCCDD with be=4'b0101; read addr 5 -> 0x11BB33DD.
- Read addr 20 with DEPTH=16 -> rd_valid=1, rd_err=1, rd_data=0. Write to addr 20 -> no array word changes (verified by reading all 16 words).
- Same-cycle write 0x55 and read at addr 7 (old value 0x0) -> 0x0 without RAM_BYPASS_EN, 0x55 with it.
- clr_req pulse with DEPTH=16 -> busy high exactly 16 cycles, then a single clr_done pulse; rd_en during busy gives no rd_valid; all 16 words then read 0.
- Drop resetn at cycle 6 of a clear -> busy=0 and rd_valid=0 immediately, no clr_done; words 0..5 read 0 and words 6..15 keep their prior data.
